gpu_mem_arbiter: RTL and testbench
==================================

Name: gpu_mem_arbiter

Overview:
- Shares one memory port between NUM_THREADS thread decode units.
- Each decode unit issues one load/store at a time. The arbiter picks one requester round-robin, drives the transaction to memory, waits for the memory response and returns the response to the winning thread.
- Only one transaction is outstanding at a time.
- Sits between the per-thread decode stage and the data memory controller.

Parameters:
- NUM_THREADS, 4, number of requesting thread decode units (2..16).
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_THREADS  per-thread request pending.
- req_we  in  NUM_THREADS  per-thread write enable (1 = store, 0 = load).
- req_addr  in  NUM_THREADS*ADDR_W  packed addresses; thread i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_THREADS*DATA_W  packed store data, same packing.
- req_ready  out  NUM_THREADS  one-hot accept; the request is taken on the cycle req_valid[i] & req_ready[i].
- rsp_valid  out  NUM_THREADS  one-hot, one-cycle response pulse.
- rsp_rdata  out  DATA_W  load data; valid with rsp_valid.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts the request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rsp_valid  in  1  memory completion (loads and stores).
- mem_rsp_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port name reset. All flops clear immediately on reset assertion.
- Reset values:
  - state = IDLE; rr_ptr = NUM_THREADS-1, so thread 0 has first priority.
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0.
  - mem_req_valid = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational and one-hot for the winner: the first i with req_valid[i] set, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_THREADS.
  - If a winner exists: latch grant index, we, addr and wdata; go to ISSUE.
  - If req_valid == 0: stay in IDLE; req_ready = 0.
- ISSUE:
  - mem_req_valid = 1; mem_we/addr/wdata come from the latches and hold stable until accepted.
  - mem_req_valid & mem_req_ready -> WAIT.
- WAIT:
  - Hold until mem_rsp_valid.
  - On mem_rsp_valid: register mem_rsp_rdata into rsp_rdata; go to RESP.
- RESP:
  - rsp_valid[grant] = 1 for exactly one cycle; rsp_rdata holds its value.
  - For stores, rsp_rdata still takes whatever memory returned on mem_rsp_rdata.
  - rr_ptr <= grant; next state IDLE.
- Latency, zero memory wait:
  - Request accepted in cycle T.
  - mem_req_valid in T+1; memory accepts in T+1.
  - mem_rsp_valid in T+2.
  - rsp_valid in T+3.
  - Next accept possible in T+4.
- Requester rules:
  - req_* must be held stable from assertion until req_ready.
  - A requester must not re-request before its rsp_valid; the arbiter does not check this.
- Fairness: a thread that is continuously requesting waits at most NUM_THREADS-1 other transactions.
- Boundary conditions:
  - mem_rsp_valid outside WAIT, including the same cycle as the ISSUE accept: ignored; memory guarantees a response no earlier than the cycle after accept.
  - req_valid changing while state != IDLE: ignored; req_ready stays 0.
  - rr_ptr wrap: after NUM_THREADS-1 the search continues at 0.
  - Reset mid-operation from any state: return to IDLE immediately. The in-flight transaction is dropped and no rsp_valid is produced. Memory is reset by the same signal.

Decomposition:
- Shared package gpu_mem_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP; 2-bit encoding);
  - default ADDR_W/DATA_W constants;
  - a log2 function for the grant index width.
- One natural sub-module, gpu_rr_arbiter: combinational rotating-priority pick with inputs req[N] and ptr and outputs one-hot gnt[N] plus index.

Test Plan:
- Reset then single load: thread 2 loads addr 0x10; memory returns 0xA5 one cycle after accept -> rsp_valid = 0b0100 with rsp_rdata = 0xA5 at T+3; busy low at T+4.
- Store: thread 0 stores 0x3C to 0x22 -> mem_we = 1, mem_addr = 0x22, mem_wdata = 0x3C while mem_req_valid is high; rsp_valid = 0b0001 after mem_rsp_valid.
- All four threads requesting continuously -> grant order 0, 1, 2, 3, 0; no thread is served twice before all others are served.
- Back-pressure: mem_req_ready low for 5 cycles -> mem_req_valid/addr/wdata held stable across all 5; no req_ready pulses in that time.
- Stray mem_rsp_valid in IDLE and in ISSUE -> no rsp_valid, state unchanged. Reset asserted in WAIT -> all outputs 0 asynchronously, and the next request goes to thread 0 first.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// Shared types and constants for the GPU memory-port arbiter.
// Holds the FSM state encoding, default bus widths and the grant-index width helper.
package gpu_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Ceiling log2, never below 1 so a 2-entry index still has a bit.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/gpu_rr_arbiter.sv
// Combinational rotating-priority pick: searches ptr+1, ptr+2, ... modulo N
// and returns the first requester as a one-hot grant plus its index.
module gpu_rr_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  int unsigned      pos;
  logic [IDX_W-1:0] pos_i;

  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    pos   = 0;
    pos_i = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos   = (32'(ptr) + k) % N;
      pos_i = IDX_W'(pos);
      if (!any_c && req[pos_i]) begin
        any_c        = 1'b1;
        gnt_c[pos_i] = 1'b1;
        idx_c        = pos_i;
      end
    end
  end

endmodule

// File: rtl/gpu_mem_arbiter.sv
// Shares one memory port among NUM_THREADS decode units, one transaction at a time,
// picking requesters round-robin and returning each response to its winning thread.
module gpu_mem_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_THREADS-1:0]        req_valid,
  input  logic [NUM_THREADS-1:0]        req_we,
  input  logic [NUM_THREADS*ADDR_W-1:0] req_addr,
  input  logic [NUM_THREADS*DATA_W-1:0] req_wdata,
  output logic [NUM_THREADS-1:0]        req_ready,
  output logic [NUM_THREADS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic                          mem_rsp_valid,
  input  logic [DATA_W-1:0]             mem_rsp_rdata,
  output logic                          busy
);

  localparam int unsigned IDX_W = idx_width(NUM_THREADS);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [NUM_THREADS-1:0] arb_gnt;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_any;

  gpu_rr_arbiter #(
    .N     (NUM_THREADS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .gnt_c (arb_gnt),
    .idx_c (arb_idx),
    .any_c (arb_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // rr_ptr resets to the last thread so thread 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= IDX_W'(NUM_THREADS - 1);
      grant_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_any)       state_d = ISSUE;
      ISSUE:   if (mem_req_ready) state_d = WAIT;
      WAIT:    if (mem_rsp_valid) state_d = RESP;
      RESP:                       state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Latch the winner's request on accept; capture read data only while waiting.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    if (state_q == IDLE && arb_any) begin
      grant_d = arb_idx;
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
        if (arb_gnt[i]) begin
          we_d    = req_we[i];
          addr_d  = req_addr[i*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[i*DATA_W +: DATA_W];
        end
      end
    end
    if (state_q == WAIT && mem_rsp_valid) begin
      rsp_rdata_d = mem_rsp_rdata;
    end
    if (state_q == RESP) begin
      rr_ptr_d = grant_q;
    end
  end

  // req_ready is gated by reset so no accept is offered while the block is held in reset.
  always_comb begin
    req_ready     = '0;
    rsp_valid     = '0;
    mem_req_valid = 1'b0;
    unique case (state_q)
      IDLE:  if (!reset) req_ready = arb_gnt;
      ISSUE: mem_req_valid = 1'b1;
      RESP: begin
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
          rsp_valid[i] = (grant_q == IDX_W'(i));
        end
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Directed bench for gpu_mem_arbiter: expected responses are queued at issue time
// and checked by an independent monitor against what the DUT returns.
module tb_gpu_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rsp_valid;
  logic [7:0]  mem_rsp_rdata;
  logic        busy;

  gpu_mem_arbiter #(
    .NUM_THREADS (4),
    .ADDR_W      (8),
    .DATA_W      (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .busy          (busy)
  );

  typedef struct packed {
    logic [3:0] oh;
    logic [7:0] rd;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] mem_model [256];
  bit         hs_prev;
  logic       hs_we;
  logic [7:0] hs_addr;
  logic [7:0] hs_wdata;
  int         stall_cycles = 0;
  bit         hold_rsp = 0;
  bit         stray_rsp = 0;
  logic [3:0] acc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [3:0] oh, input logic [7:0] rd);
    exp_t e;
    e.oh = oh;
    e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic post(input int t, input logic we, input logic [7:0] addr, input logic [7:0] wd);
    req_we[t]          = we;
    req_addr[t*8 +: 8]  = addr;
    req_wdata[t*8 +: 8] = wd;
    req_valid[t]       = 1'b1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (!busy && req_valid == 4'b0 && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: drain timeout, busy=%0b req_valid=0x%0h pending=%0d", name, busy, req_valid, sb.size());
    end
  endtask

  // Requester side: drop req_valid on the negedge after each accept.
  initial begin
    acc = 4'b0;
    forever begin
      @(negedge clk);
      req_valid = req_valid & ~acc;
      #3;
      acc = reset ? 4'b0 : (req_valid & req_ready);
    end
  end

  // Memory model: optional stall, response one cycle after accept, stores return 0x5A.
  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 8'h00;
    hs_prev       = 1'b0;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
    mem_model[8'h10] = 8'hA5;
    mem_model[8'h40] = 8'h11;
    mem_model[8'h41] = 8'h22;
    mem_model[8'h42] = 8'h33;
    mem_model[8'h43] = 8'h44;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      if (reset) begin
        hs_prev       = 1'b0;
        mem_req_ready = 1'b0;
      end else begin
        if (hs_prev && !hold_rsp) begin
          mem_rsp_valid = 1'b1;
          if (hs_we) begin
            mem_rsp_rdata      = 8'h5A;
            mem_model[hs_addr] = hs_wdata;
          end else begin
            mem_rsp_rdata = mem_model[hs_addr];
          end
        end
        hs_prev       = 1'b0;
        mem_req_ready = 1'b0;
        if (mem_req_valid) begin
          if (stall_cycles > 0) begin
            stall_cycles--;
          end else begin
            mem_req_ready = 1'b1;
            hs_prev       = 1'b1;
            hs_we         = mem_we;
            hs_addr       = mem_addr;
            hs_wdata      = mem_wdata;
          end
        end
        if (stray_rsp) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = 8'hEE;
          stray_rsp     = 1'b0;
        end
      end
    end
  end

  // Monitor: every response is matched against the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (busy) chk("ready_while_busy", 32'(req_ready), 32'h0);
        if (rsp_valid != 4'b0) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rsp: got rsp_valid=0x%0h rdata=0x%0h expected none", rsp_valid, rsp_rdata);
          end else begin
            e = sb.pop_front();
            chk("rsp_thread", 32'(rsp_valid), 32'(e.oh));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rd));
          end
        end
      end
    end
  end

  initial begin
    bit seen;
    reset     = 1'b1;
    req_valid = 4'b0;
    req_we    = 4'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Single load from thread 2 with exact latency.
    @(negedge clk);
    push_exp(4'b0100, 8'hA5);
    post(2, 1'b0, 8'h10, 8'h00);
    #1 chk("t1_req_ready", 32'(req_ready), 32'h4);
    repeat (2) @(negedge clk);
    #1 chk("t1_no_early_rsp", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    #1;
    chk("t1_rsp_valid_T3", 32'(rsp_valid), 32'h4);
    chk("t1_rsp_rdata_T3", 32'(rsp_rdata), 32'hA5);
    @(negedge clk);
    #1 chk("t1_busy_T4", 32'(busy), 32'h0);

    // Store from thread 0, then read it back from thread 1.
    @(negedge clk);
    push_exp(4'b0001, 8'h5A);
    post(0, 1'b1, 8'h22, 8'h3C);
    @(negedge clk);
    #1;
    chk("st_mem_req_valid", 32'(mem_req_valid), 32'h1);
    chk("st_mem_we", 32'(mem_we), 32'h1);
    chk("st_mem_addr", 32'(mem_addr), 32'h22);
    chk("st_mem_wdata", 32'(mem_wdata), 32'h3C);
    wait_drain(60, "store");
    push_exp(4'b0010, 8'h3C);
    post(1, 1'b0, 8'h22, 8'h00);
    wait_drain(60, "load_back");

    // Back-pressure: 5 stalled cycles while thread 3 is also waiting.
    @(negedge clk);
    stall_cycles = 5;
    push_exp(4'b0100, 8'h33);
    push_exp(4'b1000, 8'h44);
    post(2, 1'b0, 8'h42, 8'h77);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) post(3, 1'b0, 8'h43, 8'h00);
      #1;
      chk("bp_mem_req_valid", 32'(mem_req_valid), 32'h1);
      chk("bp_mem_addr", 32'(mem_addr), 32'h42);
      chk("bp_mem_wdata", 32'(mem_wdata), 32'h77);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
    end
    wait_drain(60, "backpressure");

    // Round robin with all four requesting; thread 0 re-requests after its response.
    @(negedge clk);
    push_exp(4'b0001, 8'h11);
    push_exp(4'b0010, 8'h22);
    push_exp(4'b0100, 8'h33);
    push_exp(4'b1000, 8'h44);
    push_exp(4'b0001, 8'hA5);
    for (int t = 0; t < 4; t++) post(t, 1'b0, 8'(8'h40 + t), 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid[0]) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL rr_first_rsp: no response for thread 0 within budget");
    end
    post(0, 1'b0, 8'h10, 8'h00);
    wait_drain(120, "round_robin");

    // Stray memory response in IDLE.
    @(negedge clk);
    #1 stray_rsp = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("stray_idle_busy", 32'(busy), 32'h0);
    chk("stray_idle_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("stray_idle_rsp_rdata", 32'(rsp_rdata), 32'hA5);

    // Stray memory response while the request is stalled in ISSUE.
    @(negedge clk);
    stall_cycles = 3;
    push_exp(4'b0100, 8'hA5);
    post(2, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    #1 stray_rsp = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("stray_issue_busy", 32'(busy), 32'h1);
    chk("stray_issue_mem_req_valid", 32'(mem_req_valid), 32'h1);
    chk("stray_issue_rsp_valid", 32'(rsp_valid), 32'h0);
    wait_drain(60, "stray_issue");

    // Reset while waiting on memory; the in-flight load from thread 1 is dropped.
    @(negedge clk);
    hold_rsp = 1'b1;
    post(1, 1'b0, 8'h41, 8'h00);
    @(negedge clk);
    @(negedge clk);
    #1 chk("rst_wait_busy_before", 32'(busy), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("rst_wait_busy", 32'(busy), 32'h0);
    chk("rst_wait_mem_req_valid", 32'(mem_req_valid), 32'h0);
    chk("rst_wait_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_wait_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_wait_rsp_rdata", 32'(rsp_rdata), 32'h0);
    chk("rst_wait_req_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b0;
    hold_rsp  = 1'b0;
    req_valid = 4'b0;
    @(negedge clk);
    push_exp(4'b0001, 8'h22);
    push_exp(4'b1000, 8'h3C);
    post(3, 1'b0, 8'h22, 8'h00);
    post(0, 1'b0, 8'h41, 8'h00);
    wait_drain(60, "after_reset");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
